// File: rtl/enc_pkg.sv
// Shared definitions for the iterative Feistel cipher.
//   state_e  : controller states IDLE -> RUN -> DONE
//   cnt_w()  : round-counter width, $clog2(rounds) but never below 1 bit
//   STATS_W  : width of the optional completed-block counter
package enc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int CNT_W_MIN = 1;
  localparam int STATS_W   = 16;

  function automatic int cnt_w(input int rounds);
    return ($clog2(rounds) > CNT_W_MIN) ? $clog2(rounds) : CNT_W_MIN;
  endfunction

endpackage

// File: rtl/enc_round_f.sv
// Feistel round function F(X, K), purely combinational.
//   x_i [WIDTH/2] : half-block operand
//   k_i [WIDTH]   : round key
//   f_o [WIDTH/2] : F result
// The half block is expanded to full width (upper half = X rotated left by
// one, lower half = X bit-reversed), keyed by XOR, and the two halves are
// summed together with key bit 0; the carry out is dropped.
module enc_round_f #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH/2-1:0] x_i,
  input  logic [WIDTH-1:0]   k_i,
  output logic [WIDTH/2-1:0] f_o
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] t;

  always_comb begin
    e = '0;
    e[WIDTH-1:H] = {x_i[H-2:0], x_i[H-1]};
    for (int i = 0; i < H; i++) e[i] = x_i[H-1-i];
    t = e ^ k_i;
  end

  assign f_o = t[WIDTH-1:H] + t[H-1:0] + {{(H-1){1'b0}}, k_i[0]};

endmodule

// File: rtl/iter_feistel_cipher.sv
// Iterative Feistel block cipher, one round per clock.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake; a block is taken when both high
//   in_data, in_key       : block and key, sampled only at accept
//   in_decrypt            : 0 = encrypt, 1 = decrypt (sampled at accept)
//   out_valid / out_ready : output handshake; out_data held while waiting
//   out_data              : result block
//   blk_count             : completed-block count, saturating (only when
//                           ENC_STATS_EN is defined)
// Optional feature macro: ENC_STATS_EN.
// One block is in flight at a time. After the final round one extra edge
// copies {L,R} into out_data, so out_valid rises ROUNDS+1 edges after accept.
module iter_feistel_cipher
  import enc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_key,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ENC_STATS_EN
  ,
  output logic [STATS_W-1:0] blk_count
`endif
);
  localparam int H  = WIDTH / 2;
  localparam int CW = cnt_w(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fin_q, fin_d;   // all rounds applied, output load pending
  logic [H-1:0]     l_q, l_d;
  logic [H-1:0]     r_q, r_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             dec_q, dec_d;
  logic [WIDTH-1:0] out_q, out_d;

  // Round key: block key rotated left by (round index mod WIDTH).
  int unsigned        sh;
  logic [2*WIDTH-1:0] kk;
  logic [WIDTH-1:0]   rk;
  logic [H-1:0]       f_x;
  logic [H-1:0]       f;
  logic               last_rnd;

  always_comb begin
    sh = int'(cnt_q) % WIDTH;
    kk = {key_q, key_q} << sh;
    rk = kk[2*WIDTH-1:WIDTH];
  end

  // Single F instance: encrypt feeds R, decrypt feeds L.
  assign f_x = dec_q ? l_q : r_q;

  enc_round_f #(.WIDTH(WIDTH)) u_f (
    .x_i (f_x),
    .k_i (rk),
    .f_o (f)
  );

  // Encrypt counts up to ROUNDS-1, decrypt counts down to 0.
  assign last_rnd = dec_q ? (cnt_q == '0) : (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    l_d     = l_q;
    r_d     = r_q;
    key_d   = key_q;
    dec_d   = dec_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = in_data[WIDTH-1:H];
          r_d     = in_data[H-1:0];
          key_d   = in_key;
          dec_d   = in_decrypt;
          cnt_d   = in_decrypt ? LAST : '0;
          fin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!fin_q) begin
          if (dec_q) begin
            l_d = r_q ^ f;
            r_d = l_q;
          end else begin
            l_d = r_q;
            r_d = l_q ^ f;
          end
          if (last_rnd)   fin_d = 1'b1;
          else if (dec_q) cnt_d = cnt_q - CW'(1);
          else            cnt_d = cnt_q + CW'(1);
        end else begin
          out_d   = {l_q, r_q};
          fin_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      l_q     <= '0;
      r_q     <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      l_q     <= l_d;
      r_q     <= r_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

`ifdef ENC_STATS_EN
  logic [STATS_W-1:0] blk_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)
      blk_cnt_q <= '0;
    else if (out_valid && out_ready && (blk_cnt_q != '1))
      blk_cnt_q <= blk_cnt_q + STATS_W'(1);
  end

  assign blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_iter_feistel_cipher.sv
module tb_iter_feistel_cipher;
  // Instance 0: WIDTH=8 ROUNDS=1, instance 1: WIDTH=16 ROUNDS=20,
  // instance 2: WIDTH=8 ROUNDS=4.
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  reset, in_valid, in_dec, out_ready, in_ready, out_valid;
  logic [15:0] in_data [3];
  logic [15:0] in_key  [3];
  logic [7:0]  od0, od2;
  logic [15:0] od1;
`ifdef ENC_STATS_EN
  logic [15:0] bc0, bc1, bc2;
`endif

  int checks = 0;
  int failures = 0;

  iter_feistel_cipher #(.WIDTH(8), .ROUNDS(1)) u0 (
    .clock(clock), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .in_key(in_key[0][7:0]), .in_decrypt(in_dec[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0)
`ifdef ENC_STATS_EN
    , .blk_count(bc0)
`endif
  );

  iter_feistel_cipher #(.WIDTH(16), .ROUNDS(20)) u1 (
    .clock(clock), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_key(in_key[1]), .in_decrypt(in_dec[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1)
`ifdef ENC_STATS_EN
    , .blk_count(bc1)
`endif
  );

  iter_feistel_cipher #(.WIDTH(8), .ROUNDS(4)) u2 (
    .clock(clock), .reset(reset[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .in_key(in_key[2][7:0]), .in_decrypt(in_dec[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2)
`ifdef ENC_STATS_EN
    , .blk_count(bc2)
`endif
  );

  function automatic int w_of(input int u);
    return (u == 1) ? 16 : 8;
  endfunction

  function automatic int r_of(input int u);
    return (u == 0) ? 1 : (u == 1) ? 20 : 4;
  endfunction

  function automatic logic [15:0] get_out(input int u);
    case (u)
      0:       return {8'h00, od0};
      1:       return od1;
      default: return {8'h00, od2};
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic int unsigned f_ref(input int w, input int unsigned x, input int unsigned k);
    int h;
    int unsigned mh, e, t;
    h  = w / 2;
    mh = (1 << h) - 1;
    e  = 0;
    for (int i = 0; i < h; i++) begin
      if (((x >> i) & 1) != 0) begin
        e |= 1 << (h + (i + 1) % h);   // rotate-left-by-one into upper half
        e |= 1 << (h - 1 - i);         // bit-reversed into lower half
      end
    end
    t = e ^ k;
    return ((t >> h) + (t & mh) + (k & 1)) & mh;
  endfunction

  function automatic int unsigned rotl(input int w, input int unsigned k, input int n);
    int unsigned m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((1 << w) - 1);
    if (n == 0) return k & m;
    return ((k << n) | (k >> (w - n))) & m;
  endfunction

  function automatic int unsigned cipher(input int w, input int r, input int unsigned d,
                                         input int unsigned k, input bit dec);
    int h;
    int unsigned mh, l, rr, nl;
    h  = w / 2;
    mh = (1 << h) - 1;
    l  = (d >> h) & mh;
    rr = d & mh;
    for (int s = 0; s < r; s++) begin
      int i;
      i = dec ? (r - 1 - s) : s;
      if (!dec) begin
        nl = rr;
        rr = l ^ f_ref(w, rr, rotl(w, k, i % w));
        l  = nl;
      end else begin
        nl = rr ^ f_ref(w, l, rotl(w, k, i % w));
        rr = l;
        l  = nl;
      end
    end
    return (l << h) | rr;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_blk(input int u, input logic [15:0] d, input logic [15:0] k, input bit dec);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready[u] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_key[u]   = k;
    in_dec[u]   = dec;
    @(posedge clock);
    #1;
    in_valid[u] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int u, output int lat);
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input int u);
    @(negedge clock);
    out_ready[u] = 1'b1;
    @(posedge clock);
    #1;
    out_ready[u] = 1'b0;
  endtask

  task automatic run_blk(input int u, input logic [15:0] d, input logic [15:0] k, input bit dec,
                         output logic [15:0] res, output int lat);
    start_blk(u, d, k, dec);
    wait_out(u, lat);
    res = get_out(u);
    consume(u);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] res, res2, held, d, k;
  int lat;
  bit dec;

  initial begin
    reset = 3'b111; in_valid = '0; in_dec = '0; out_ready = '0;
    for (int u = 0; u < 3; u++) begin in_data[u] = '0; in_key[u] = '0; end
    repeat (2) @(posedge clock);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_in_ready%0d", u), 32'(in_ready[u]), 32'd1);
      chk($sformatf("rst_out_valid%0d", u), 32'(out_valid[u]), 32'd0);
      chk($sformatf("rst_out_data%0d", u), 32'(get_out(u)), 32'd0);
    end
    @(negedge clock);
    reset = 3'b000;

    // Known vectors, WIDTH=8 ROUNDS=1
    run_blk(0, 16'h46, 16'h93, 1'b0, res, lat);
    chk("vec_enc", 32'(res), 32'h6F);
    chk("vec_enc_lat", 32'(lat), 32'd2);
    run_blk(0, 16'h6F, 16'h93, 1'b1, res, lat);
    chk("vec_dec", 32'(res), 32'h46);
    chk("vec_dec_lat", 32'(lat), 32'd2);
    d = 16'($urandom_range(0, 255)); k = 16'($urandom_range(0, 255));
    run_blk(0, d, k, 1'b0, res, lat);
    chk("r1_rand_enc", 32'(res), cipher(8, 1, d, k, 1'b0));

`ifdef ENC_STATS_EN
    chk("stats_three", 32'(bc0), 32'd3);
    @(negedge clock);
    force u0.blk_cnt_q = 16'hFFFE;
    #1;
    release u0.blk_cnt_q;
    run_blk(0, 16'h12, 16'h34, 1'b0, res, lat);
    chk("stats_fffe_plus1", 32'(bc0), 32'hFFFF);
    run_blk(0, 16'h56, 16'h78, 1'b1, res, lat);
    chk("stats_saturate", 32'(bc0), 32'hFFFF);
`endif

    // Round-trip with key-rotation wrap, WIDTH=16 ROUNDS=20
    for (int n = 0; n < 200; n++) begin
      d = 16'($urandom); k = 16'($urandom);
      run_blk(1, d, k, 1'b0, res, lat);
      chk("w16_enc", 32'(res), cipher(16, 20, d, k, 1'b0));
      chk("w16_enc_lat", 32'(lat), 32'd21);
      run_blk(1, res, k, 1'b1, res2, lat);
      chk("w16_roundtrip", 32'(res2), 32'(d));
      chk("w16_dec_lat", 32'(lat), 32'd21);
    end

    // Random both modes, WIDTH=8 ROUNDS=4
    for (int n = 0; n < 20; n++) begin
      d = 16'($urandom_range(0, 255)); k = 16'($urandom_range(0, 255));
      dec = 1'($urandom_range(0, 1));
      run_blk(2, d, k, dec, res, lat);
      chk("r4_rand", 32'(res), cipher(8, 4, d, k, dec));
      chk("r4_lat", 32'(lat), 32'd5);
    end

    // Backpressure in DONE
    d = 16'hA5; k = 16'h3C;
    start_blk(2, d, k, 1'b0);
    wait_out(2, lat);
    held = get_out(2);
    chk("bp_first", 32'(held), cipher(8, 4, d, k, 1'b0));
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      in_valid[2] = c[0];
      in_data[2]  = 16'($urandom_range(0, 255));
      in_key[2]   = 16'($urandom_range(0, 255));
      in_dec[2]   = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      chk("bp_out_valid", 32'(out_valid[2]), 32'd1);
      chk("bp_out_data", 32'(get_out(2)), 32'(held));
      chk("bp_in_ready", 32'(in_ready[2]), 32'd0);
    end
    in_valid[2] = 1'b0;
    consume(2);
    for (int c = 0; c < 3; c++) begin
      chk("bp_no_ghost_valid", 32'(out_valid[2]), 32'd0);
      chk("bp_idle_ready", 32'(in_ready[2]), 32'd1);
      @(posedge clock);
      #1;
    end
    d = 16'h5A; k = 16'hC3;
    run_blk(2, d, k, 1'b1, res, lat);
    chk("bp_next_blk", 32'(res), cipher(8, 4, d, k, 1'b1));

    // Reset mid-RUN
    start_blk(2, 16'h77, 16'h99, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    reset[2] = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_out_valid", 32'(out_valid[2]), 32'd0);
    chk("midrst_out_data", 32'(get_out(2)), 32'd0);
    chk("midrst_in_ready", 32'(in_ready[2]), 32'd1);
    @(negedge clock);
    reset[2] = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      chk("midrst_stays_idle", 32'(out_valid[2]), 32'd0);
    end
    d = 16'h3E; k = 16'h81;
    run_blk(2, d, k, 1'b0, res, lat);
    chk("midrst_next_blk", 32'(res), cipher(8, 4, d, k, 1'b0));
    chk("midrst_next_lat", 32'(lat), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
